// File: rtl/pdua_pkg.sv
// Shared definitions for the PDUA control unit: opcodes, ALU select codes,
// register-bank addresses, FSM state encoding and opcode classification.
package pdua_pkg;

    // Instruction opcodes as held in the IR
    localparam logic [4:0] OP_NOP       = 5'b00000;
    localparam logic [4:0] OP_MOV_ACC_A = 5'b00001;
    localparam logic [4:0] OP_MOV_A_ACC = 5'b00010;
    localparam logic [4:0] OP_MOV_ACC_K = 5'b00011;
    localparam logic [4:0] OP_LD_DPTR   = 5'b00100;
    localparam logic [4:0] OP_ST_DPTR   = 5'b00101;
    localparam logic [4:0] OP_ADD       = 5'b00110;
    localparam logic [4:0] OP_AND       = 5'b00111;
    localparam logic [4:0] OP_NOT       = 5'b01000;
    localparam logic [4:0] OP_SHL       = 5'b01001;
    localparam logic [4:0] OP_JMP       = 5'b01010;
    localparam logic [4:0] OP_JZ        = 5'b01011;
    localparam logic [4:0] OP_JN        = 5'b01100;
    localparam logic [4:0] OP_JC        = 5'b01101;
    localparam logic [4:0] OP_HALT      = 5'b11111;

    // ALU operation select codes
    localparam logic [2:0] SEL_PASS = 3'b000;
    localparam logic [2:0] SEL_ADD  = 3'b001;
    localparam logic [2:0] SEL_AND  = 3'b010;
    localparam logic [2:0] SEL_NOT  = 3'b011;
    localparam logic [2:0] SEL_SHL  = 3'b101;
    localparam logic [2:0] SEL_INC  = 3'b110;

    // Register-bank addresses
    localparam logic [2:0] REG_PC   = 3'b000;
    localparam logic [2:0] REG_DPTR = 3'b010;
    localparam logic [2:0] REG_A    = 3'b011;
    localparam logic [2:0] REG_ACC  = 3'b111;

    // Control FSM states
    typedef enum logic [3:0] {
        CLR,
        F_MAR,
        F_MEM,
        F_IR,
        DECODE,
        O_MAR,
        O_MEM,
        EXEC,
        D_MAR,
        D_MEM,
        HALT,
        ERR
    } state_t;

    // Coarse instruction classes that steer the DECODE branch
    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ONE_BYTE,
        CLS_TWO_BYTE,
        CLS_MEMORY,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    // Map an opcode onto the path it takes after DECODE
    function automatic op_class_t classify_opcode(input logic [4:0] op);
        op_class_t cls;
        case (op)
            OP_NOP:                          cls = CLS_NOP;
            OP_MOV_ACC_A, OP_MOV_A_ACC,
            OP_ADD, OP_AND, OP_NOT, OP_SHL:  cls = CLS_ONE_BYTE;
            OP_MOV_ACC_K, OP_JMP, OP_JZ,
            OP_JN, OP_JC:                    cls = CLS_TWO_BYTE;
            OP_LD_DPTR, OP_ST_DPTR:          cls = CLS_MEMORY;
            OP_HALT:                         cls = CLS_HALT;
            default:                         cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/pdua_control_unit.sv
// PDUA control unit: single FSM sequencing fetch, operand fetch, data-memory
// access and execute. State is registered; outputs are decoded from the
// current state (plus mem_ready in the memory-wait states and the ALU flags
// for conditional jumps in EXEC).
module pdua_control_unit
    import pdua_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int OPC_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OPC_WIDTH-1:0]  out_IR,
    input  logic                  C,
    input  logic                  N,
    input  logic                  P,
    input  logic                  Z,
    input  logic                  mem_ready,
    output logic                  wr_rdn,
    output logic                  enaf,
    output logic [2:0]            selop,
    output logic [1:0]            shamt,
    output logic                  bank_wr_en,
    output logic [ADDR_WIDTH-1:0] BusB_addr,
    output logic [ADDR_WIDTH-1:0] BusC_addr,
    output logic                  sclr,
    output logic                  ir_en,
    output logic                  mar_en,
    output logic                  mdr_en,
    output logic                  mdr_alu_n,
    output logic                  halted,
    output logic                  illegal
);

    state_t    state;
    state_t    state_next;
    logic [4:0] opcode;
    op_class_t op_class;
    logic      jump_taken;
    logic [2:0] busb_sel;
    logic [2:0] busc_sel;
    logic      parity_flag_unused;

    assign opcode   = 5'(out_IR);
    assign op_class = classify_opcode(opcode);

    // Parity is part of the flag interface but no instruction tests it
    assign parity_flag_unused = P;

    // Jump condition, evaluated against the flags present during EXEC
    always_comb begin
        jump_taken = 1'b0;
        case (opcode)
            OP_JMP:  jump_taken = 1'b1;
            OP_JZ:   jump_taken = Z;
            OP_JN:   jump_taken = N;
            OP_JC:   jump_taken = C;
            default: jump_taken = 1'b0;
        endcase
    end

    // Next-state logic; memory-wait states only advance once mem_ready is seen
    always_comb begin
        state_next = state;
        case (state)
            CLR:    state_next = F_MAR;
            F_MAR:  state_next = F_MEM;
            F_MEM:  if (mem_ready) state_next = F_IR;
            F_IR:   state_next = DECODE;
            DECODE: begin
                case (op_class)
                    CLS_NOP:      state_next = F_MAR;
                    CLS_ONE_BYTE: state_next = EXEC;
                    CLS_TWO_BYTE: state_next = O_MAR;
                    CLS_MEMORY:   state_next = D_MAR;
                    CLS_HALT:     state_next = HALT;
                    default:      state_next = ERR;
                endcase
            end
            O_MAR:  state_next = O_MEM;
            O_MEM:  if (mem_ready) state_next = EXEC;
            D_MAR:  state_next = D_MEM;
            D_MEM: begin
                if (mem_ready) begin
                    state_next = (opcode == OP_ST_DPTR) ? F_MAR : EXEC;
                end
            end
            EXEC:   state_next = F_MAR;
            HALT:   state_next = HALT;
            ERR:    state_next = ERR;
            default: state_next = CLR;
        endcase
    end

    // State register; reset wins from any state, including memory waits
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLR;
        end else begin
            state <= state_next;
        end
    end

    // Output decode; reset forces the idle defaults with the datapath clear
    always_comb begin
        wr_rdn     = 1'b0;
        enaf       = 1'b0;
        selop      = SEL_PASS;
        shamt      = 2'b00;
        bank_wr_en = 1'b0;
        busb_sel   = REG_PC;
        busc_sel   = REG_PC;
        sclr       = 1'b0;
        ir_en      = 1'b0;
        mar_en     = 1'b0;
        mdr_en     = 1'b0;
        mdr_alu_n  = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;
        if (rst) begin
            sclr = 1'b1;
        end else begin
            case (state)
                CLR: sclr = 1'b1;
                F_MAR, O_MAR: mar_en = 1'b1;
                F_MEM, O_MEM: begin
                    mdr_en = 1'b1;
                    if (mem_ready) begin
                        selop      = SEL_INC;
                        busc_sel   = REG_PC;
                        bank_wr_en = 1'b1;
                    end
                end
                F_IR: begin
                    ir_en     = 1'b1;
                    mdr_alu_n = 1'b1;
                end
                D_MAR: begin
                    busb_sel = REG_DPTR;
                    mar_en   = 1'b1;
                end
                D_MEM: begin
                    if (opcode == OP_ST_DPTR) begin
                        busb_sel = REG_ACC;
                        wr_rdn   = 1'b1;
                    end else begin
                        mdr_en = 1'b1;
                    end
                end
                EXEC: begin
                    case (opcode)
                        OP_MOV_ACC_A: begin
                            busb_sel   = REG_A;
                            busc_sel   = REG_ACC;
                            bank_wr_en = 1'b1;
                        end
                        OP_MOV_A_ACC: begin
                            busb_sel   = REG_ACC;
                            busc_sel   = REG_A;
                            bank_wr_en = 1'b1;
                        end
                        OP_MOV_ACC_K, OP_LD_DPTR: begin
                            busc_sel   = REG_ACC;
                            mdr_alu_n  = 1'b1;
                            bank_wr_en = 1'b1;
                        end
                        OP_ADD, OP_AND: begin
                            busb_sel   = REG_A;
                            busc_sel   = REG_ACC;
                            selop      = (opcode == OP_ADD) ? SEL_ADD : SEL_AND;
                            enaf       = 1'b1;
                            bank_wr_en = 1'b1;
                        end
                        OP_NOT, OP_SHL: begin
                            busb_sel   = REG_ACC;
                            busc_sel   = REG_ACC;
                            selop      = (opcode == OP_NOT) ? SEL_NOT : SEL_SHL;
                            shamt      = (opcode == OP_SHL) ? 2'b01 : 2'b00;
                            enaf       = 1'b1;
                            bank_wr_en = 1'b1;
                        end
                        OP_JMP, OP_JZ, OP_JN, OP_JC: begin
                            if (jump_taken) begin
                                busc_sel   = REG_PC;
                                mdr_alu_n  = 1'b1;
                                bank_wr_en = 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
                HALT: halted  = 1'b1;
                ERR:  illegal = 1'b1;
                default: begin
                end
            endcase
        end
    end

    assign BusB_addr = ADDR_WIDTH'(busb_sel);
    assign BusC_addr = ADDR_WIDTH'(busc_sel);

endmodule

// File: tb/tb_pdua_control_unit.sv
// Directed testbench for pdua_control_unit: each cycle's expected output
// vector is queued as the stimulus is driven and checked at the falling edge.
module tb_pdua_control_unit;

    typedef struct packed {
        logic       wr_rdn;
        logic       enaf;
        logic [2:0] selop;
        logic [1:0] shamt;
        logic       bank_wr_en;
        logic [2:0] busb;
        logic [2:0] busc;
        logic       sclr;
        logic       ir_en;
        logic       mar_en;
        logic       mdr_en;
        logic       mdr_alu_n;
        logic       halted;
        logic       illegal;
    } outv_t;

    logic       clk;
    logic       rst;
    logic [4:0] ir;
    logic       c_flag;
    logic       n_flag;
    logic       p_flag;
    logic       z_flag;
    logic       mem_ready;
    logic       wr_rdn;
    logic       enaf;
    logic [2:0] selop;
    logic [1:0] shamt;
    logic       bank_wr_en;
    logic [2:0] busb_addr;
    logic [2:0] busc_addr;
    logic       sclr;
    logic       ir_en;
    logic       mar_en;
    logic       mdr_en;
    logic       mdr_alu_n;
    logic       halted;
    logic       illegal;
    outv_t      observed;

    outv_t exp_q[$];
    string tag_q[$];
    int    vectors_applied;
    int    miscompares;

    pdua_control_unit #(
        .ADDR_WIDTH(3),
        .OPC_WIDTH(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .out_IR(ir),
        .C(c_flag),
        .N(n_flag),
        .P(p_flag),
        .Z(z_flag),
        .mem_ready(mem_ready),
        .wr_rdn(wr_rdn),
        .enaf(enaf),
        .selop(selop),
        .shamt(shamt),
        .bank_wr_en(bank_wr_en),
        .BusB_addr(busb_addr),
        .BusC_addr(busc_addr),
        .sclr(sclr),
        .ir_en(ir_en),
        .mar_en(mar_en),
        .mdr_en(mdr_en),
        .mdr_alu_n(mdr_alu_n),
        .halted(halted),
        .illegal(illegal)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    assign observed = {wr_rdn, enaf, selop, shamt, bank_wr_en, busb_addr, busc_addr,
                       sclr, ir_en, mar_en, mdr_en, mdr_alu_n, halted, illegal};

    // Expected-vector builders for the recurring control patterns
    function automatic outv_t v_none();
        outv_t v;
        v = '0;
        return v;
    endfunction

    function automatic outv_t v_sclr();
        outv_t v;
        v = '0;
        v.sclr = 1'b1;
        return v;
    endfunction

    function automatic outv_t v_mar(input logic [2:0] b);
        outv_t v;
        v = '0;
        v.busb   = b;
        v.mar_en = 1'b1;
        return v;
    endfunction

    function automatic outv_t v_mem_wait();
        outv_t v;
        v = '0;
        v.mdr_en = 1'b1;
        return v;
    endfunction

    function automatic outv_t v_pc_inc();
        outv_t v;
        v = '0;
        v.mdr_en     = 1'b1;
        v.selop      = 3'b110;
        v.bank_wr_en = 1'b1;
        return v;
    endfunction

    function automatic outv_t v_ir();
        outv_t v;
        v = '0;
        v.ir_en     = 1'b1;
        v.mdr_alu_n = 1'b1;
        return v;
    endfunction

    function automatic outv_t v_write();
        outv_t v;
        v = '0;
        v.wr_rdn = 1'b1;
        v.busb   = 3'b111;
        return v;
    endfunction

    function automatic outv_t v_exec(input logic [2:0] b, input logic [2:0] c,
                                     input logic [2:0] sel, input logic [1:0] sh,
                                     input logic f, input logic m);
        outv_t v;
        v = '0;
        v.bank_wr_en = 1'b1;
        v.busb       = b;
        v.busc       = c;
        v.selop      = sel;
        v.shamt      = sh;
        v.enaf       = f;
        v.mdr_alu_n  = m;
        return v;
    endfunction

    function automatic outv_t v_status(input logic h, input logic i);
        outv_t v;
        v = '0;
        v.halted  = h;
        v.illegal = i;
        return v;
    endfunction

    // Drive this cycle's inputs and queue the outputs they should produce
    task automatic applyStimulus(input string tag, input logic r, input logic mr,
                                 input outv_t exp);
        rst       = r;
        mem_ready = mr;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    // Pop the oldest expectation and compare it with the DUT outputs
    task automatic checkOutput();
        outv_t exp;
        string tag;
        vectors_applied++;
        assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("[TB] FAIL scoreboard_empty: observed %06h required a queued vector", observed);
        end
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            assert (observed === exp) else begin
                miscompares++;
                $error("[TB] FAIL %s: observed %06h required %06h", tag, observed, exp);
            end
        end
    endtask

    // One clock cycle: drive after the rising edge, check at the falling edge
    task automatic step(input string tag, input logic r, input logic mr, input outv_t exp);
        applyStimulus(tag, r, mr, exp);
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    // Instruction fetch up to and including DECODE
    task automatic fetch(input logic [4:0] op, input int waits);
        ir = op;
        step("f_mar", 1'b0, 1'b1, v_mar(3'b000));
        for (int i = 0; i < waits; i++) begin
            step("f_mem_wait", 1'b0, 1'b0, v_mem_wait());
        end
        step("f_mem", 1'b0, 1'b1, v_pc_inc());
        step("f_ir", 1'b0, 1'b1, v_ir());
        step("decode", 1'b0, 1'b1, v_none());
    endtask

    // Operand byte fetch for two-byte instructions
    task automatic operand(input int waits);
        step("o_mar", 1'b0, 1'b1, v_mar(3'b000));
        for (int i = 0; i < waits; i++) begin
            step("o_mem_wait", 1'b0, 1'b0, v_mem_wait());
        end
        step("o_mem", 1'b0, 1'b1, v_pc_inc());
    endtask

    initial begin
        clk             = 1'b0;
        rst             = 1'b1;
        mem_ready       = 1'b1;
        ir              = 5'b00000;
        c_flag          = 1'b0;
        n_flag          = 1'b0;
        p_flag          = 1'b0;
        z_flag          = 1'b0;
        vectors_applied = 0;
        miscompares     = 0;

        // Reset and release: one CLR cycle with sclr
        step("reset_0", 1'b1, 1'b1, v_sclr());
        step("reset_1", 1'b1, 1'b1, v_sclr());
        step("clr", 1'b0, 1'b1, v_sclr());

        // MOV ACC,A
        fetch(5'b00001, 0);
        step("mov_acc_a_exec", 1'b0, 1'b1, v_exec(3'b011, 3'b111, 3'b000, 2'b00, 1'b0, 1'b0));

        // NOP returns straight to fetch
        fetch(5'b00000, 0);

        // ALU instructions, ADD with one fetch wait state
        fetch(5'b00110, 1);
        step("add_exec", 1'b0, 1'b1, v_exec(3'b011, 3'b111, 3'b001, 2'b00, 1'b1, 1'b0));
        fetch(5'b00111, 0);
        step("and_exec", 1'b0, 1'b1, v_exec(3'b011, 3'b111, 3'b010, 2'b00, 1'b1, 1'b0));
        fetch(5'b01001, 0);
        step("shl_exec", 1'b0, 1'b1, v_exec(3'b111, 3'b111, 3'b101, 2'b01, 1'b1, 1'b0));
        fetch(5'b01000, 0);
        step("not_exec", 1'b0, 1'b1, v_exec(3'b111, 3'b111, 3'b011, 2'b00, 1'b1, 1'b0));

        // MOV A,ACC
        fetch(5'b00010, 0);
        step("mov_a_acc_exec", 1'b0, 1'b1, v_exec(3'b111, 3'b011, 3'b000, 2'b00, 1'b0, 1'b0));

        // MOV ACC,#k with two operand wait states
        fetch(5'b00011, 0);
        operand(2);
        step("mov_acc_k_exec", 1'b0, 1'b1, v_exec(3'b000, 3'b111, 3'b000, 2'b00, 1'b0, 1'b1));

        // JZ not taken, then taken
        z_flag = 1'b0;
        fetch(5'b01011, 0);
        operand(0);
        step("jz_not_taken", 1'b0, 1'b1, v_none());
        z_flag = 1'b1;
        fetch(5'b01011, 0);
        operand(0);
        step("jz_taken", 1'b0, 1'b1, v_exec(3'b000, 3'b000, 3'b000, 2'b00, 1'b0, 1'b1));
        z_flag = 1'b0;

        // JN not taken, JC taken
        n_flag = 1'b0;
        fetch(5'b01100, 0);
        operand(0);
        step("jn_not_taken", 1'b0, 1'b1, v_none());
        c_flag = 1'b1;
        fetch(5'b01101, 0);
        operand(0);
        step("jc_taken", 1'b0, 1'b1, v_exec(3'b000, 3'b000, 3'b000, 2'b00, 1'b0, 1'b1));
        c_flag = 1'b0;

        // MOV ACC,[DPTR] with one data wait state
        fetch(5'b00100, 0);
        step("ld_d_mar", 1'b0, 1'b1, v_mar(3'b010));
        step("ld_d_mem_wait", 1'b0, 1'b0, v_mem_wait());
        step("ld_d_mem", 1'b0, 1'b1, v_mem_wait());
        step("ld_exec", 1'b0, 1'b1, v_exec(3'b000, 3'b111, 3'b000, 2'b00, 1'b0, 1'b1));

        // MOV [DPTR],ACC with three data wait states, then back to fetch
        fetch(5'b00101, 0);
        step("st_d_mar", 1'b0, 1'b1, v_mar(3'b010));
        for (int i = 0; i < 3; i++) begin
            step("st_d_mem_wait", 1'b0, 1'b0, v_write());
        end
        step("st_d_mem", 1'b0, 1'b1, v_write());

        // Reset during a fetch stall: no PC write, back to CLR
        step("stall_f_mar", 1'b0, 1'b1, v_mar(3'b000));
        step("stall_wait_0", 1'b0, 1'b0, v_mem_wait());
        step("stall_wait_1", 1'b0, 1'b0, v_mem_wait());
        step("stall_reset", 1'b1, 1'b1, v_sclr());
        step("stall_clr", 1'b0, 1'b1, v_sclr());

        // Undefined opcode: sticky illegal until reset
        fetch(5'b10101, 0);
        step("illegal_0", 1'b0, 1'b1, v_status(1'b0, 1'b1));
        step("illegal_1", 1'b0, 1'b0, v_status(1'b0, 1'b1));
        step("illegal_reset", 1'b1, 1'b1, v_sclr());
        step("illegal_clr", 1'b0, 1'b1, v_sclr());

        // HALT: sticky halted until reset
        fetch(5'b11111, 0);
        step("halt_0", 1'b0, 1'b1, v_status(1'b1, 1'b0));
        step("halt_1", 1'b0, 1'b0, v_status(1'b1, 1'b0));
        step("halt_reset", 1'b1, 1'b1, v_sclr());
        step("halt_clr", 1'b0, 1'b1, v_sclr());
        step("final_f_mar", 1'b0, 1'b1, v_mar(3'b000));

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
